conv_arbiter: RTL and testbench

Shares one single-operand float-to-integer converter between NUM_REQ stimulus producers that use the team's stb/ack stream handshake. Grants requesters round-robin, issues one operand to the converter, collects the result and returns it to the originating requester. Sits between the file-driven stimulus readers and the converter under test in the Converter_F2I bench, and in any datapath that timeshares the converter.

---
 rtl/conv_arb_pkg.sv | 11 +
 rtl/conv_arb_rr_pick.sv | 28 ++
 rtl/conv_arbiter.sv | 115 +++++++++++
 tb/tb_conv_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_arb_pkg.sv
// conv_arb_pkg: shared types, constants and helpers for conv_arbiter
//   state_t        arbiter FSM states
//   TIMEOUT_RESULT result returned to a requester when the converter watchdog fires
//   tag_w()        requester tag width, never below 1 bit
package conv_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RETURN} state_t;
  localparam logic [31:0] TIMEOUT_RESULT = 32'h8000_0000;
  function automatic int tag_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/conv_arb_rr_pick.sv
// conv_arb_rr_pick: combinational round-robin selector
//   i_stb  request vector
//   i_ptr  highest-priority index
//   o_idx  first set index at or after i_ptr (wrapping)
//   o_vld  any request set
module conv_arb_rr_pick import conv_arb_pkg::*; #(
  parameter int NUM_REQ = 2,
  parameter int TW = tag_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_stb,
  input  logic [TW-1:0]      i_ptr,
  output logic [TW-1:0]      o_idx,
  output logic               o_vld
);
  localparam logic [TW:0] W_N = (TW+1)'(NUM_REQ);
  logic [NUM_REQ-1:0] w_rot;
  logic [TW-1:0] w_off;
  logic [TW:0] w_sum;
  // rotate so that bit 0 is the requester at i_ptr
  assign w_rot = NUM_REQ'({i_stb, i_stb} >> i_ptr);
  always_comb begin
    w_off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) if (w_rot[i]) w_off = TW'(i);
  end
  assign w_sum = {1'b0, i_ptr} + {1'b0, w_off};
  assign o_idx = (w_sum >= W_N) ? TW'(w_sum - W_N) : w_sum[TW-1:0];
  assign o_vld = |i_stb;
endmodule

// File: rtl/conv_arbiter.sv
// conv_arbiter: round-robin sharing of one float-to-int converter between NUM_REQ stb/ack requesters
//   clk, rst                          clock, synchronous active-high reset
//   req_a/req_a_stb/req_a_ack         per-requester operand streams (32 bits each, packed)
//   res_z/res_z_stb/res_z_ack         result returned to the granted requester (one-hot stb)
//   conv_a/conv_a_stb/conv_a_ack      operand to converter
//   conv_z/conv_z_stb/conv_z_ack      result from converter
//   busy, done_count, timeout_err     status
//   CONV_ARB_TIMEOUT_EN (macro)       enables the TIMEOUT_CYCLES converter watchdog
module conv_arbiter import conv_arb_pkg::*; #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [NUM_REQ-1:0]     req_a_stb,
  output logic [NUM_REQ-1:0]     req_a_ack,
  output logic [31:0]            res_z,
  output logic [NUM_REQ-1:0]     res_z_stb,
  input  logic [NUM_REQ-1:0]     res_z_ack,
  output logic [31:0]            conv_a,
  output logic                   conv_a_stb,
  input  logic                   conv_a_ack,
  input  logic [31:0]            conv_z,
  input  logic                   conv_z_stb,
  output logic                   conv_z_ack,
  output logic                   busy,
  output logic [15:0]            done_count,
  output logic                   timeout_err
);
  localparam int TW = tag_w(NUM_REQ);
  state_t r_state;
  logic [TW-1:0] r_tag, r_ptr, w_idx;
  logic w_vld, w_to;
  conv_arb_rr_pick #(.NUM_REQ(NUM_REQ), .TW(TW)) u_pick (
    .i_stb(req_a_stb),
    .i_ptr(r_ptr),
    .o_idx(w_idx),
    .o_vld(w_vld)
  );
`ifdef CONV_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  logic r_terr;
  // a real handshake in the same cycle wins over the watchdog
  assign w_to = (r_state == ISSUE || r_state == WAIT) && r_cnt == CW'(TIMEOUT_CYCLES - 1)
              && !(conv_a_stb && conv_a_ack) && !(conv_z_stb && conv_z_ack);
  always_ff @(posedge clk) begin
    r_cnt <= (rst || r_state == IDLE) ? '0 : r_cnt + 1'b1;
    r_terr <= !rst && (r_terr || w_to);
  end
  assign timeout_err = r_terr;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign w_to = 1'b0;
  assign timeout_err = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_tag <= '0;
      r_ptr <= '0;
      req_a_ack <= '0;
      res_z_stb <= '0;
      conv_a_stb <= 1'b0;
      conv_z_ack <= 1'b0;
      conv_a <= '0;
      res_z <= '0;
      busy <= 1'b0;
      done_count <= '0;
    end else begin
      req_a_ack <= '0;
      case (r_state)
        IDLE: if (w_vld) begin
          conv_a <= req_a[{w_idx, 5'd0} +: 32];
          r_tag <= w_idx;
          req_a_ack[w_idx] <= 1'b1;
          conv_a_stb <= 1'b1;
          busy <= 1'b1;
          r_state <= ISSUE;
        end
        ISSUE: if (conv_a_stb && conv_a_ack) begin
          conv_a_stb <= 1'b0;
          conv_z_ack <= 1'b1;
          r_state <= WAIT;
        end else if (w_to) begin
          conv_a_stb <= 1'b0;
          res_z <= TIMEOUT_RESULT;
          res_z_stb[r_tag] <= 1'b1;
          r_state <= RETURN;
        end
        WAIT: if (conv_z_stb && conv_z_ack) begin
          res_z <= conv_z;
          conv_z_ack <= 1'b0;
          res_z_stb[r_tag] <= 1'b1;
          r_state <= RETURN;
        end else if (w_to) begin
          conv_z_ack <= 1'b0;
          res_z <= TIMEOUT_RESULT;
          res_z_stb[r_tag] <= 1'b1;
          r_state <= RETURN;
        end
        RETURN: if (res_z_ack[r_tag]) begin
          res_z_stb <= '0;
          r_ptr <= (r_tag == TW'(NUM_REQ - 1)) ? '0 : r_tag + 1'b1;
          done_count <= done_count + 1'b1;
          busy <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_arbiter.sv
// tb_conv_arbiter: scoreboard bench for conv_arbiter with two requesters and a converter model
module tb_conv_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] rd [2];
  logic [63:0] req_a;
  logic [1:0] req_a_stb = '0, req_a_ack, res_z_stb, res_z_ack = '0;
  logic [31:0] res_z, conv_a, conv_z = '0;
  logic conv_a_stb, conv_a_ack = 1'b0, conv_z_stb = 1'b0, conv_z_ack, busy, timeout_err;
  logic [15:0] done_count;
  typedef struct { int idx; logic [31:0] val; } exp_t;
  exp_t sb [$];
  logic [31:0] ops0 [$], ops1 [$];
  int checks = 0, errors = 0;
  int a_delay = 0, res_delay = 0, conv_lat = 0;
  bit no_resp = 0;
  logic [1:0] hs_a;
  logic c_hs_a, c_hs_z;
  logic [31:0] cap;
  int n_conv = 0, n_res = 0;

  assign req_a = {rd[1], rd[0]};
  always #5 clk = ~clk;

  conv_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_a_stb(req_a_stb), .req_a_ack(req_a_ack),
    .res_z(res_z), .res_z_stb(res_z_stb), .res_z_ack(res_z_ack),
    .conv_a(conv_a), .conv_a_stb(conv_a_stb), .conv_a_ack(conv_a_ack),
    .conv_z(conv_z), .conv_z_stb(conv_z_stb), .conv_z_ack(conv_z_ack),
    .busy(busy), .done_count(done_count), .timeout_err(timeout_err)
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  function automatic logic [31:0] f2i(input logic [31:0] f);
    int e;
    logic [31:0] m;
    e = int'(f[30:23]) - 127;
    m = {8'd1, f[22:0]};
    if (e < 0) m = '0;
    else if (e <= 23) m = m >> (23 - e);
    else m = m << (e - 23);
    return f[31] ? -m : m;
  endfunction

  always @(posedge clk) begin
    hs_a <= req_a_stb & req_a_ack;
    c_hs_a <= conv_a_stb & conv_a_ack;
    c_hs_z <= conv_z_stb & conv_z_ack;
    if (conv_a_stb && conv_a_ack) begin
      cap <= conv_a;
      n_conv <= n_conv + 1;
    end
    if (|(res_z_stb & res_z_ack)) n_res <= n_res + 1;
  end

  // requesters: hold stb and data until the handshake, then load the next operand
  initial begin
    rd[0] = '0;
    rd[1] = '0;
    forever begin
      @(negedge clk);
      for (int r = 0; r < 2; r++) begin
        if (rst || hs_a[r] === 1'b1) req_a_stb[r] = 1'b0;
        if (!req_a_stb[r] && !rst) begin
          if (r == 0 && ops0.size() > 0) begin rd[0] = ops0.pop_front(); req_a_stb[0] = 1'b1; end
          else if (r == 1 && ops1.size() > 0) begin rd[1] = ops1.pop_front(); req_a_stb[1] = 1'b1; end
        end
      end
    end
  end

  // result consumers with programmable back-pressure
  initial begin
    int rw [2];
    rw[0] = 0;
    rw[1] = 0;
    forever begin
      @(negedge clk);
      for (int r = 0; r < 2; r++) begin
        if (res_z_stb[r] && !rst) begin
          if (rw[r] > 0) begin rw[r]--; res_z_ack[r] = 1'b0; end
          else res_z_ack[r] = 1'b1;
        end else begin
          res_z_ack[r] = 1'b0;
          rw[r] = res_delay;
        end
      end
    end
  end

  // converter model
  initial begin
    int stall, lat;
    bit have;
    logic [31:0] held;
    stall = 0; lat = 0; have = 0; held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        conv_a_ack = 1'b0;
        conv_z_stb = 1'b0;
        have = 0;
      end else begin
        if (c_hs_z === 1'b1) conv_z_stb = 1'b0;
        if (c_hs_a === 1'b1) begin
          conv_a_ack = 1'b0;
          have = !no_resp;
          held = f2i(cap);
          lat = conv_lat;
        end
        if (have && !conv_z_stb) begin
          if (lat == 0) begin conv_z = held; conv_z_stb = 1'b1; have = 0; end
          else lat--;
        end
        if (!conv_a_stb) stall = a_delay;
        else if (!conv_a_ack && c_hs_a !== 1'b1) begin
          if (stall == 0) conv_a_ack = 1'b1;
          else stall--;
        end
      end
    end
  end

  // monitor: pop the scoreboard on each new result, check holds and ack pulses
  initial begin
    bit seen;
    logic [31:0] shown, prev_ca;
    logic [1:0] prev_ack;
    logic prev_cstb;
    exp_t e;
    seen = 0; shown = '0; prev_ca = '0; prev_ack = '0; prev_cstb = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 0; prev_ack = '0; prev_cstb = 1'b0;
      end else begin
        if (res_z_stb != 2'b00) begin
          if (!seen) begin
            seen = 1;
            shown = res_z;
            if (sb.size() == 0) begin
              checks++; errors++;
              $display("FAIL res_unexpected: got stb %b res %h expected no result", res_z_stb, res_z);
            end else begin
              e = sb.pop_front();
              chk("res_idx", 32'(res_z_stb), 32'(1) << e.idx);
              chk("res_val", res_z, e.val);
            end
          end else chk("res_hold", res_z, shown);
        end else seen = 0;
        if (req_a_ack != 2'b00) begin
          chk("ack_pulse", 32'(req_a_ack & prev_ack), 0);
          chk("ack_onehot", 32'($countones(req_a_ack)), 1);
        end
        if (prev_cstb && conv_a_stb) chk("conv_a_hold", conv_a, prev_ca);
        prev_ack = req_a_ack;
        prev_cstb = conv_a_stb;
        prev_ca = conv_a;
      end
    end
  end

  task automatic drain(input string n, input int budget);
    int c = 0;
    do begin @(negedge clk); c++; end
    while ((sb.size() != 0 || busy || ops0.size() != 0 || ops1.size() != 0) && c < budget);
    checks++;
    if (sb.size() != 0 || busy) begin
      errors++;
      $display("FAIL %s_drain: got %0d results pending busy=%b expected 0 pending", n, sb.size(), busy);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_reset(input string n);
    chk({n, "_req_a_ack"}, 32'(req_a_ack), 0);
    chk({n, "_res_z_stb"}, 32'(res_z_stb), 0);
    chk({n, "_conv_a_stb"}, 32'(conv_a_stb), 0);
    chk({n, "_conv_z_ack"}, 32'(conv_z_ack), 0);
    chk({n, "_conv_a"}, conv_a, 0);
    chk({n, "_res_z"}, res_z, 0);
    chk({n, "_busy"}, 32'(busy), 0);
    chk({n, "_done_count"}, 32'(done_count), 0);
    chk({n, "_timeout_err"}, 32'(timeout_err), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "aborted");
  end

  initial begin
    int base_c, base_r, c;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;

    // single request, with grant latency checks
    @(posedge clk);
    sb.push_back('{0, 32'h1});
    ops0.push_back(32'h3F80_0000);
    @(negedge clk);
    @(negedge clk);
    chk("t1_conv_a_stb", 32'(conv_a_stb), 1);
    chk("t1_req_a_ack", 32'(req_a_ack), 32'b01);
    chk("t1_conv_a", conv_a, 32'h3F80_0000);
    chk("t1_busy", 32'(busy), 1);
    @(negedge clk);
    chk("t1_ack_gone", 32'(req_a_ack), 0);
    drain("t1", 100);
    chk("t1_done", 32'(done_count), 1);
    chk("t1_busy_low", 32'(busy), 0);

    // both requesters continuously active: grants alternate 0,1,0,1,0,1
    reset_dut();
    @(posedge clk);
    sb.push_back('{0, 32'd2});
    sb.push_back('{1, 32'd5});
    sb.push_back('{0, 32'd3});
    sb.push_back('{1, 32'd10});
    sb.push_back('{0, 32'd4});
    sb.push_back('{1, 32'hFFFF_FFFE});
    ops0.push_back(32'h4000_0000); ops0.push_back(32'h4040_0000); ops0.push_back(32'h4080_0000);
    ops1.push_back(32'h40A0_0000); ops1.push_back(32'h4120_0000); ops1.push_back(32'hC000_0000);
    drain("rr", 300);
    chk("rr_done", 32'(done_count), 6);

    // back-pressure on both sides
    a_delay = 10;
    res_delay = 5;
    base_c = n_conv;
    base_r = n_res;
    @(posedge clk);
    sb.push_back('{0, 32'd100});
    ops0.push_back(32'h42C8_0000);
    c = 0;
    do begin @(negedge clk); c++; end while (!conv_a_stb && c < 20);
    repeat (5) @(negedge clk);
    chk("bp_stb_held", 32'(conv_a_stb), 1);
    chk("bp_conv_a", conv_a, 32'h42C8_0000);
    chk("bp_no_zack", 32'(conv_z_ack), 0);
    drain("bp", 200);
    chk("bp_done", 32'(done_count), 7);
    chk("bp_conv_hs", 32'(n_conv - base_c), 1);
    chk("bp_res_hs", 32'(n_res - base_r), 1);
    a_delay = 0;
    res_delay = 0;

    // reset while waiting for the converter result
    conv_lat = 20;
    @(posedge clk);
    ops1.push_back(32'h4040_0000);
    c = 0;
    do begin @(negedge clk); c++; end while (!conv_z_ack && c < 30);
    chk("mid_in_wait", 32'(conv_z_ack), 1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset("mid");
    @(negedge clk);
    rst = 1'b0;
    conv_lat = 0;
    @(posedge clk);
    sb.push_back('{0, 32'd1});
    sb.push_back('{1, 32'd2});
    ops0.push_back(32'h3F80_0000);
    ops1.push_back(32'h4000_0000);
    drain("mid", 200);
    chk("mid_done", 32'(done_count), 2);

`ifdef CONV_ARB_TIMEOUT_EN
    // converter never answers: watchdog result, then normal service with sticky flag
    reset_dut();
    no_resp = 1;
    @(posedge clk);
    sb.push_back('{0, 32'h8000_0000});
    ops0.push_back(32'h4000_0000);
    drain("to", 100);
    chk("to_err", 32'(timeout_err), 1);
    no_resp = 0;
    @(posedge clk);
    sb.push_back('{1, 32'd4});
    ops1.push_back(32'h4080_0000);
    drain("to_next", 100);
    chk("to_err_sticky", 32'(timeout_err), 1);
    chk("to_done", 32'(done_count), 2);
`else
    chk("to_err_off", 32'(timeout_err), 0);
`endif

    // done_count wrap, preloaded to the last value before wrapping
    reset_dut();
    force dut.done_count = 16'hFFFF;
    @(negedge clk);
    release dut.done_count;
    @(negedge clk);
    chk("wrap_preload", 32'(done_count), 32'hFFFF);
    @(posedge clk);
    sb.push_back('{0, 32'd1});
    ops0.push_back(32'h3F80_0000);
    drain("wrap", 100);
    chk("wrap_done", 32'(done_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
